point_array_sequencer: RTL and testbench

- Owns the register array of soft-body points (pos/vel per point) for the squishy car.
- Sits directly upstream of update_point. On each frame strobe it walks every point in turn: applies gravity to vel_y, launches one update_point run, waits for that run's result, and writes the new state back.
- Emits a frame-done pulse consumed by the frame/render logic.
- Provides an init write port and a combinational read port for the renderer.

---
 rtl/point_array_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_point_array_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_array_sequencer.sv
// Soft-body point store for the squishy car. Holds pos/vel for every point
// and, once per frame, walks each point through update_point: gravity is
// added to vel_y on the way out and the returned state is written back.
module point_array_sequencer #(
  parameter int NUM_POINTS    = 8,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter logic signed [VELOCITY_SIZE-1:0] GRAVITY = -1,
  parameter int TIMEOUT       = 1024,
  localparam int IDX_W        = $clog2(NUM_POINTS)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            frame_start_in,
  input  logic                            init_we_in,
  input  logic        [IDX_W-1:0]         init_idx_in,
  input  logic signed [POSITION_SIZE-1:0] init_pos_x_in,
  input  logic signed [POSITION_SIZE-1:0] init_pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0] init_vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0] init_vel_y_in,
  input  logic        [IDX_W-1:0]         rd_idx_in,
  output logic signed [POSITION_SIZE-1:0] rd_pos_x_out,
  output logic signed [POSITION_SIZE-1:0] rd_pos_y_out,
  output logic                            upd_begin_out,
  output logic signed [POSITION_SIZE-1:0] upd_pos_x_out,
  output logic signed [POSITION_SIZE-1:0] upd_pos_y_out,
  output logic signed [VELOCITY_SIZE-1:0] upd_vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0] upd_vel_y_out,
  input  logic signed [POSITION_SIZE-1:0] upd_new_pos_x_in,
  input  logic signed [POSITION_SIZE-1:0] upd_new_pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0] upd_new_vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0] upd_new_vel_y_in,
  input  logic                            upd_result_in,
  output logic                            busy_out,
  output logic                            frame_done_out,
  output logic                            timeout_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_POINTS - 1);
  localparam logic signed [VELOCITY_SIZE-1:0] VEL_MAX = {1'b0, {(VELOCITY_SIZE-1){1'b1}}};
  localparam logic signed [VELOCITY_SIZE-1:0] VEL_MIN = {1'b1, {(VELOCITY_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    WRITE,
    SKIP,
    DONE
  } state_t;

  state_t                         state_q;
  logic        [IDX_W-1:0]        idx_q;
  logic        [CNT_W-1:0]        cnt_q;

  logic signed [POSITION_SIZE-1:0] pos_x_q [NUM_POINTS];
  logic signed [POSITION_SIZE-1:0] pos_y_q [NUM_POINTS];
  logic signed [VELOCITY_SIZE-1:0] vel_x_q [NUM_POINTS];
  logic signed [VELOCITY_SIZE-1:0] vel_y_q [NUM_POINTS];

  logic                            upd_begin_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            err_q;
  logic signed [POSITION_SIZE-1:0] upd_pos_x_q;
  logic signed [POSITION_SIZE-1:0] upd_pos_y_q;
  logic signed [VELOCITY_SIZE-1:0] upd_vel_x_q;
  logic signed [VELOCITY_SIZE-1:0] upd_vel_y_q;

  logic        [IDX_W-1:0]         launch_idx_d;
  logic signed [POSITION_SIZE-1:0] src_pos_x_d;
  logic signed [POSITION_SIZE-1:0] src_pos_y_d;
  logic signed [VELOCITY_SIZE-1:0] src_vel_x_d;
  logic signed [VELOCITY_SIZE-1:0] src_vel_y_d;
  logic        [VELOCITY_SIZE:0]   vel_y_sum_d;
  logic signed [VELOCITY_SIZE-1:0] vel_y_sat_d;

  // Pick the point about to be launched (bypassing a same-cycle init write
  // so a frame started alongside a write sees the new value) and apply
  // saturating gravity to its vel_y.
  always_comb begin
    launch_idx_d = (state_q == IDLE) ? '0 : idx_q + 1'b1;
    src_pos_x_d  = pos_x_q[launch_idx_d];
    src_pos_y_d  = pos_y_q[launch_idx_d];
    src_vel_x_d  = vel_x_q[launch_idx_d];
    src_vel_y_d  = vel_y_q[launch_idx_d];
    if (state_q == IDLE && init_we_in && init_idx_in == launch_idx_d) begin
      src_pos_x_d = init_pos_x_in;
      src_pos_y_d = init_pos_y_in;
      src_vel_x_d = init_vel_x_in;
      src_vel_y_d = init_vel_y_in;
    end
    vel_y_sum_d = {src_vel_y_d[VELOCITY_SIZE-1], src_vel_y_d}
                + {GRAVITY[VELOCITY_SIZE-1], GRAVITY};
    vel_y_sat_d = vel_y_sum_d[VELOCITY_SIZE-1:0];
    if (vel_y_sum_d[VELOCITY_SIZE] != vel_y_sum_d[VELOCITY_SIZE-1]) begin
      vel_y_sat_d = vel_y_sum_d[VELOCITY_SIZE] ? VEL_MIN : VEL_MAX;
    end
  end

  // Frame sequencer: owns the point array, the walk index, the wait
  // counter and every registered output.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      upd_begin_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      upd_pos_x_q <= '0;
      upd_pos_y_q <= '0;
      upd_vel_x_q <= '0;
      upd_vel_y_q <= '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
        vel_x_q[i] <= '0;
        vel_y_q[i] <= '0;
      end
    end else begin
      upd_begin_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (init_we_in) begin
            pos_x_q[init_idx_in] <= init_pos_x_in;
            pos_y_q[init_idx_in] <= init_pos_y_in;
            vel_x_q[init_idx_in] <= init_vel_x_in;
            vel_y_q[init_idx_in] <= init_vel_y_in;
          end
          if (frame_start_in) begin
            state_q     <= LAUNCH;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            upd_begin_q <= 1'b1;
            upd_pos_x_q <= src_pos_x_d;
            upd_pos_y_q <= src_pos_y_d;
            upd_vel_x_q <= src_vel_x_d;
            upd_vel_y_q <= vel_y_sat_d;
          end
        end
        LAUNCH: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: begin
          if (cnt_q != '0 && upd_result_in) begin
            state_q <= WRITE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= SKIP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE, SKIP: begin
          if (state_q == WRITE) begin
            pos_x_q[idx_q] <= upd_new_pos_x_in;
            pos_y_q[idx_q] <= upd_new_pos_y_in;
            vel_x_q[idx_q] <= upd_new_vel_x_in;
            vel_y_q[idx_q] <= upd_new_vel_y_in;
          end else begin
            err_q <= 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= LAUNCH;
            idx_q       <= launch_idx_d;
            upd_begin_q <= 1'b1;
            upd_pos_x_q <= src_pos_x_d;
            upd_pos_y_q <= src_pos_y_d;
            upd_vel_x_q <= src_vel_x_d;
            upd_vel_y_q <= vel_y_sat_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_pos_x_out    = pos_x_q[rd_idx_in];
  assign rd_pos_y_out    = pos_y_q[rd_idx_in];
  assign upd_begin_out   = upd_begin_q;
  assign upd_pos_x_out   = upd_pos_x_q;
  assign upd_pos_y_out   = upd_pos_y_q;
  assign upd_vel_x_out   = upd_vel_x_q;
  assign upd_vel_y_out   = upd_vel_y_q;
  assign busy_out        = busy_q;
  assign frame_done_out  = done_q;
  assign timeout_err_out = err_q;

endmodule

// File: tb/tb_point_array_sequencer.sv
// Scoreboard bench for point_array_sequencer: a behavioural update_point
// responder, a frame-level reference model of the point array, and a
// monitor that checks every launch and frame-done pulse against queued
// expectations.
module tb_point_array_sequencer;

  localparam int NP = 8;
  localparam int PS = 8;
  localparam int VS = 8;
  localparam int TO = 1024;
  localparam int IW = $clog2(NP);
  localparam logic signed [VS-1:0] GRAV = -1;

  typedef struct packed {
    logic [PS-1:0] px;
    logic [PS-1:0] py;
    logic [VS-1:0] vx;
    logic [VS-1:0] vy;
  } launch_t;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 frame_start_in = 1'b0;
  logic                 init_we_in = 1'b0;
  logic        [IW-1:0] init_idx_in = '0;
  logic signed [PS-1:0] init_pos_x_in = '0;
  logic signed [PS-1:0] init_pos_y_in = '0;
  logic signed [VS-1:0] init_vel_x_in = '0;
  logic signed [VS-1:0] init_vel_y_in = '0;
  logic        [IW-1:0] rd_idx_in = '0;
  logic signed [PS-1:0] rd_pos_x_out, rd_pos_y_out;
  logic                 upd_begin_out;
  logic signed [PS-1:0] upd_pos_x_out, upd_pos_y_out;
  logic signed [VS-1:0] upd_vel_x_out, upd_vel_y_out;
  logic signed [PS-1:0] upd_new_pos_x_in, upd_new_pos_y_in;
  logic signed [VS-1:0] upd_new_vel_x_in, upd_new_vel_y_in;
  logic                 upd_result_in;
  logic                 busy_out, frame_done_out, timeout_err_out;

  int      checks = 0;
  int      failures = 0;
  int      mPx [NP];
  int      mPy [NP];
  int      mVx [NP];
  int      mVy [NP];
  int      respLat [NP];
  int      respIdx = 0;
  bit      holdMode = 1'b0;
  bit      expErr = 1'b0;
  launch_t launchQ [$];
  int      doneQ [$];
  int      cycleCount = 0;
  int      launchCycle = 0;
  int      beginCount = 0;
  int      doneCount = 0;
  int      frameBase = 0;

  point_array_sequencer #(
    .NUM_POINTS(NP), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS),
    .GRAVITY(GRAV), .TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .init_we_in(init_we_in), .init_idx_in(init_idx_in),
    .init_pos_x_in(init_pos_x_in), .init_pos_y_in(init_pos_y_in),
    .init_vel_x_in(init_vel_x_in), .init_vel_y_in(init_vel_y_in),
    .rd_idx_in(rd_idx_in), .rd_pos_x_out(rd_pos_x_out), .rd_pos_y_out(rd_pos_y_out),
    .upd_begin_out(upd_begin_out),
    .upd_pos_x_out(upd_pos_x_out), .upd_pos_y_out(upd_pos_y_out),
    .upd_vel_x_out(upd_vel_x_out), .upd_vel_y_out(upd_vel_y_out),
    .upd_new_pos_x_in(upd_new_pos_x_in), .upd_new_pos_y_in(upd_new_pos_y_in),
    .upd_new_vel_x_in(upd_new_vel_x_in), .upd_new_vel_y_in(upd_new_vel_y_in),
    .upd_result_in(upd_result_in), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .timeout_err_out(timeout_err_out)
  );

  // Free-running clock
  initial forever #5 clk_in = ~clk_in;

  // Global safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int wrapP(input int v);
    logic signed [PS-1:0] t;
    t = v[PS-1:0];
    return int'(t);
  endfunction

  function automatic int wrapV(input int v);
    logic signed [VS-1:0] t;
    t = v[VS-1:0];
    return int'(t);
  endfunction

  function automatic int satV(input int v);
    int hi;
    int lo;
    hi = (1 << (VS - 1)) - 1;
    lo = -(1 << (VS - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < NP; i++) begin
      mPx[i] = 0; mPy[i] = 0; mVx[i] = 0; mVy[i] = 0;
    end
    expErr = 1'b0;
    launchQ.delete();
    doneQ.delete();
  endtask

  task automatic checkArray(input string name);
    for (int i = 0; i < NP; i++) begin
      rd_idx_in = IW'(i);
      #1;
      checkOutput($sformatf("%s_x%0d", name, i), int'(rd_pos_x_out), mPx[i]);
      checkOutput($sformatf("%s_y%0d", name, i), int'(rd_pos_y_out), mPy[i]);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_ctrl"}, int'({upd_begin_out, busy_out, frame_done_out, timeout_err_out}), 0);
    checkOutput({name, "_updPos"}, int'({upd_pos_x_out, upd_pos_y_out}), 0);
    checkOutput({name, "_updVel"}, int'({upd_vel_x_out, upd_vel_y_out}), 0);
  endtask

  task automatic initWrite(input int idx, input int px, input int py, input int vx, input int vy);
    @(negedge clk_in);
    init_we_in = 1'b1;
    init_idx_in = IW'(idx);
    init_pos_x_in = PS'(px); init_pos_y_in = PS'(py);
    init_vel_x_in = VS'(vx); init_vel_y_in = VS'(vy);
    @(negedge clk_in);
    init_we_in = 1'b0;
    mPx[idx] = wrapP(px); mPy[idx] = wrapP(py);
    mVx[idx] = wrapV(vx); mVy[idx] = wrapV(vy);
  endtask

  task automatic initRandom(input int idx);
    initWrite(idx, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
              int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
  endtask

  task automatic randomLatencies();
    for (int i = 0; i < NP; i++) respLat[i] = int'($urandom_range(7, 2));
  endtask

  // Predict one whole frame from the model, queue the expected launches and
  // frame latency, then pulse frame_start (optionally with an init write).
  task automatic applyStimulus(input bit withWrite, input int wIdx, input int wPx,
                               input int wPy, input int wVx, input int wVy);
    int      total;
    int      vy;
    launch_t e;
    if (withWrite) begin
      mPx[wIdx] = wrapP(wPx); mPy[wIdx] = wrapP(wPy);
      mVx[wIdx] = wrapV(wVx); mVy[wIdx] = wrapV(wVy);
    end
    total = 0;
    for (int i = 0; i < NP; i++) begin
      vy = satV(mVy[i] + int'(GRAV));
      e.px = PS'(mPx[i]); e.py = PS'(mPy[i]);
      e.vx = VS'(mVx[i]); e.vy = VS'(vy);
      launchQ.push_back(e);
      if (respLat[i] > 0) begin
        mPx[i] = wrapP(mPx[i] + mVx[i]);
        mPy[i] = wrapP(mPy[i] + vy);
        mVy[i] = vy;
        total += respLat[i] + 2;
      end else begin
        expErr = 1'b1;
        total += TO + 2;
      end
    end
    doneQ.push_back(total + 1);
    respIdx = 0;
    frameBase = beginCount;
    @(negedge clk_in);
    frame_start_in = 1'b1;
    if (withWrite) begin
      init_we_in = 1'b1;
      init_idx_in = IW'(wIdx);
      init_pos_x_in = PS'(wPx); init_pos_y_in = PS'(wPy);
      init_vel_x_in = VS'(wVx); init_vel_y_in = VS'(wVy);
    end
    @(negedge clk_in);
    frame_start_in = 1'b0;
    init_we_in = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int start;
    int n;
    start = doneCount;
    n = 0;
    while (doneCount == start && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (doneCount == start) checkOutput({name, "_doneTimeout"}, 0, 1);
    @(negedge clk_in);
  endtask

  task automatic endOfFrame(input string name);
    checkOutput({name, "_launchesLeft"}, launchQ.size(), 0);
    checkOutput({name, "_busy"}, int'(busy_out), 0);
    checkOutput({name, "_timeoutErr"}, int'(timeout_err_out), int'(expErr));
    checkArray(name);
  endtask

  // update_point stand-in: answers each launch with pos+vel after the
  // planned number of WAIT cycles, or keeps result high in hold mode.
  initial begin : responder
    int lat;
    logic signed [PS-1:0] nx, ny;
    upd_result_in = 1'b0;
    upd_new_pos_x_in = '0; upd_new_pos_y_in = '0;
    upd_new_vel_x_in = '0; upd_new_vel_y_in = '0;
    forever begin
      @(negedge clk_in);
      upd_result_in = holdMode;
      if (rst_in && upd_begin_out) begin
        lat = (respIdx < NP) ? respLat[respIdx] : 2;
        respIdx++;
        nx = upd_pos_x_out + upd_vel_x_out;
        ny = upd_pos_y_out + upd_vel_y_out;
        if (holdMode) begin
          upd_new_pos_x_in = nx; upd_new_pos_y_in = ny;
          upd_new_vel_x_in = upd_vel_x_out; upd_new_vel_y_in = upd_vel_y_out;
        end else if (lat > 0) begin
          repeat (lat) @(posedge clk_in);
          #1;
          upd_new_pos_x_in = nx; upd_new_pos_y_in = ny;
          upd_new_vel_x_in = upd_vel_x_out; upd_new_vel_y_in = upd_vel_y_out;
          upd_result_in = 1'b1;
          @(posedge clk_in);
          #1;
          upd_result_in = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every launch and frame-done pulse
  initial begin : monitor
    launch_t e;
    forever begin
      @(negedge clk_in);
      cycleCount++;
      if (rst_in) begin
        if (upd_begin_out) begin
          if (beginCount == frameBase) launchCycle = cycleCount;
          beginCount++;
          if (launchQ.size() == 0) begin
            checkOutput("unexpectedLaunch", 1, 0);
          end else begin
            e = launchQ.pop_front();
            checkOutput("launchData",
                        int'({upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out}),
                        int'(e));
          end
        end
        if (frame_done_out) begin
          doneCount++;
          checkOutput("busyAtDone", int'(busy_out), 0);
          if (doneQ.size() == 0) checkOutput("unexpectedDone", 1, 0);
          else checkOutput("frameLatency", cycleCount - launchCycle + 1, doneQ.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    int b0;
    int d0;
    int n;
    clearModel();
    for (int i = 0; i < NP; i++) respLat[i] = 5;
    repeat (3) @(negedge clk_in);
    checkResetOutputs("reset");
    checkArray("resetArray");
    rst_in = 1'b1;
    @(negedge clk_in);

    // Basic frame: point 0 = (2,3,-1,0), all results after 5 WAIT cycles
    initWrite(0, 2, 3, -1, 0);
    for (int i = 1; i < NP; i++) initRandom(i);
    applyStimulus(1'b0, 0, 0, 0, 0, 0);
    checkOutput("busyDuringFrame", int'(busy_out), 1);
    waitDone("frame1", 200);
    endOfFrame("frame1");
    rd_idx_in = '0;
    #1;
    checkOutput("point0X", int'(rd_pos_x_out), 1);
    checkOutput("point0Y", int'(rd_pos_y_out), 2);
    checkOutput("singleDone", doneCount, 1);

    // Gravity saturation at both ends of the velocity range
    initWrite(1, 10, -5, 3, -128);
    initWrite(2, -7, 100, -2, 127);
    initWrite(3, 0, 0, 0, -127);
    randomLatencies();
    applyStimulus(1'b0, 0, 0, 0, 0, 0);
    waitDone("sat", 200);
    endOfFrame("sat");

    // Result held high across every launch
    holdMode = 1'b1;
    for (int i = 0; i < NP; i++) respLat[i] = 2;
    b0 = beginCount;
    applyStimulus(1'b0, 0, 0, 0, 0, 0);
    waitDone("hold", 200);
    holdMode = 1'b0;
    @(negedge clk_in);
    checkOutput("holdBegins", beginCount - b0, NP);
    endOfFrame("hold");

    // Point 3 never answers
    randomLatencies();
    respLat[3] = 0;
    applyStimulus(1'b0, 0, 0, 0, 0, 0);
    waitDone("timeout", NP * (TO + 3) + 50);
    endOfFrame("timeout");
    randomLatencies();
    applyStimulus(1'b0, 0, 0, 0, 0, 0);
    waitDone("sticky", 200);
    endOfFrame("sticky");

    // frame_start and init write mid-frame are both ignored
    randomLatencies();
    b0 = beginCount;
    applyStimulus(1'b0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk_in);
    frame_start_in = 1'b1;
    init_we_in = 1'b1;
    init_idx_in = IW'(5);
    init_pos_x_in = 8'sd55; init_pos_y_in = -8'sd55;
    init_vel_x_in = 8'sd11; init_vel_y_in = 8'sd22;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    init_we_in = 1'b0;
    waitDone("midFrame", 200);
    checkOutput("midFrameBegins", beginCount - b0, NP);
    endOfFrame("midFrame");

    // Init write in the same cycle as frame_start is seen by the frame
    randomLatencies();
    applyStimulus(1'b1, 0, 40, -40, 5, 9);
    waitDone("sameCycle", 200);
    endOfFrame("sameCycle");

    // A few fully random frames
    for (int f = 0; f < 3; f++) begin
      initRandom(int'($urandom_range(NP - 1)));
      initRandom(int'($urandom_range(NP - 1)));
      randomLatencies();
      applyStimulus(1'b0, 0, 0, 0, 0, 0);
      waitDone("random", 200);
      endOfFrame("random");
    end

    // Reset during the WAIT of point 2
    for (int i = 0; i < NP; i++) respLat[i] = 5;
    d0 = doneCount;
    b0 = beginCount;
    applyStimulus(1'b0, 0, 0, 0, 0, 0);
    n = 0;
    while (beginCount < b0 + 3 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("reachedPoint2", int'(beginCount >= b0 + 3), 1);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    clearModel();
    checkResetOutputs("midReset");
    checkArray("midResetArray");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (12) @(negedge clk_in);
    checkOutput("noDoneAfterReset", doneCount, d0);
    initWrite(0, -20, 30, 4, -6);
    initWrite(1, 7, -8, 9, 10);
    for (int i = 0; i < NP; i++) respLat[i] = 3;
    applyStimulus(1'b0, 0, 0, 0, 0, 0);
    waitDone("afterReset", 200);
    endOfFrame("afterReset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
